mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter REG_DATA_WIDTH, default 32, data bus width.
REQ-002 SHALL have parameter PC_WIDTH, default 32, instruction address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum SERVE cycles before abort; legal range 2..255.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 i_req_i  in  1  fetch request, held high until granted.
REQ-007 i_addr_i  in  PC_WIDTH  fetch address.
REQ-008 i_gnt_o  out  1  fetch request accepted (combinational, IDLE only).
REQ-009 i_done_o  out  1  one-cycle fetch completion pulse.
REQ-010 i_rdata_o  out  REG_DATA_WIDTH  fetched word, registered.
REQ-011 d_req_i, d_we_i  in  1 each  data request; 1 = write, 0 = read.
REQ-012 d_addr_i, d_wdata_i  in  REG_DATA_WIDTH each  data address, store data.
REQ-013 d_gnt_o, d_done_o  out  1 each  data accept, one-cycle completion pulse.
REQ-014 d_rdata_o  out  REG_DATA_WIDTH  load data, registered.
REQ-015 mem_ce_o, mem_we_o  out  1 each  shared memory enable, write enable.
REQ-016 mem_addr_o, mem_wdata_o  out  REG_DATA_WIDTH each  shared memory address, write data.
REQ-017 mem_rdata_i  in  REG_DATA_WIDTH  memory read data.
REQ-018 mem_ready_i  in  1  memory completes the current access this cycle.
REQ-019 busy_o, err_o  out  1 each  port occupied; one-cycle timeout pulse.

Function
REQ-020 SHALL implement FSM with states IDLE, SERVE_I, SERVE_D.
REQ-021 In IDLE with exactly one req high, SHALL assert that requester's gnt and enter the matching SERVE state next cycle.
REQ-022 In IDLE with both req high, SHALL grant the requester not served last (last_d flag); after reset data wins first.
REQ-023 gnt SHALL be asserted only in IDLE, for at most one requester, for exactly one cycle per accepted request.
REQ-024 On grant, SHALL latch address, we (0 for fetch; fetch address zero-extended/truncated to REG_DATA_WIDTH) and wdata; memory outputs SHALL be driven only from latched values.
REQ-025 In SERVE states, mem_ce_o SHALL be 1 and mem_we_o SHALL equal latched we; in IDLE mem_ce_o, mem_we_o SHALL be 0.
REQ-026 In SERVE with mem_ready_i=1, SHALL pulse matching done next cycle, return to IDLE, update last_d.
REQ-027 Read completion SHALL register mem_rdata_i into matching rdata output at the ready edge; rdata SHALL hold until the next read completion of that port; writes SHALL NOT alter d_rdata_o.
REQ-028 Latency: gnt in cycle N, mem_ce_o high from N+1; ready in cycle M>=N+1 gives done and valid rdata in M+1; IDLE in M+1, so next grant no earlier than M+1.
REQ-029 mem_ready_i in IDLE SHALL be ignored.
REQ-030 SHALL count SERVE cycles with ready low; when count reaches TIMEOUT_CYCLES, SHALL abort: done and err_o pulse together next cycle, rdata of a read set to 0, return to IDLE, last_d updated.
REQ-031 Ready in the same cycle the count would reach TIMEOUT_CYCLES SHALL count as normal completion, no err_o.
REQ-032 Timeout counter SHALL clear on every grant.
REQ-033 busy_o SHALL equal (state != IDLE).
REQ-034 req inputs SHALL be ignored outside IDLE; a req dropped before grant SHALL be lost without side effect.

Reset
REQ-035 rst low SHALL immediately force IDLE, last_d=0, counter=0, all gnt/done/err_o/busy_o/mem_ce_o/mem_we_o=0, mem_addr_o/mem_wdata_o/rdata outputs=0.
REQ-036 Reset during SERVE SHALL abandon the access with no done pulse; after rst release first grant follows REQ-022.

Verification
REQ-037 Fetch alone: i_req_i=1, i_addr_i=0x100, ready 2 cycles after ce -> i_gnt_o 1 cycle, mem_addr_o=0x100, mem_we_o=0, i_done_o pulse, i_rdata_o=mem_rdata_i (0xDEADBEEF).
REQ-038 Simultaneous req after reset -> d_gnt_o first; fetch granted in d_done_o cycle; repeat with both held -> strict alternation D,I,D,I.
REQ-039 Store: d_we_i=1, d_addr_i=0x2000, d_wdata_i=0x12345678 -> mem_we_o=1 with those values while ce; d_done_o pulse; d_rdata_o unchanged.
REQ-040 Timeout: mem_ready_i held 0 -> after 16 SERVE cycles d_done_o and err_o pulse together, d_rdata_o=0, busy_o falls.
REQ-041 Reset mid-SERVE: rst low 1 cycle during SERVE_I -> all outputs 0 asynchronously, no i_done_o, next request handled normally.
REQ-042 Ready pulse in IDLE -> no done, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-outstanding memory port between an instruction-fetch
// requester (I) and a load/store requester (D). The arbiter sits in IDLE,
// grants one requester, and then serves it in SERVE_I or SERVE_D until the
// memory signals ready or the timeout expires. When both requesters ask at
// once, the one that was not served last wins.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_i/i_addr_i    fetch request and address
//   i_gnt_o             fetch accepted (combinational, IDLE only)
//   i_done_o/i_rdata_o  fetch completion pulse, registered fetch word
//   d_req_i/d_we_i      data request, 1 = write
//   d_addr_i/d_wdata_i  data address and store data
//   d_gnt_o             data accepted (combinational, IDLE only)
//   d_done_o/d_rdata_o  data completion pulse, registered load word
//   mem_*_o             shared memory command, driven from latched values
//   mem_rdata_i         memory read data
//   mem_ready_i         memory finishes the current access this cycle
//   busy_o              a SERVE state is active
//   err_o               one-cycle pulse, alongside done, on timeout abort
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned REG_DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // fetch port
  input  logic                      i_req_i,
  input  logic [PC_WIDTH-1:0]       i_addr_i,
  output logic                      i_gnt_o,
  output logic                      i_done_o,
  output logic [REG_DATA_WIDTH-1:0] i_rdata_o,
  // data port
  input  logic                      d_req_i,
  input  logic                      d_we_i,
  input  logic [REG_DATA_WIDTH-1:0] d_addr_i,
  input  logic [REG_DATA_WIDTH-1:0] d_wdata_i,
  output logic                      d_gnt_o,
  output logic                      d_done_o,
  output logic [REG_DATA_WIDTH-1:0] d_rdata_o,
  // shared memory
  output logic                      mem_ce_o,
  output logic                      mem_we_o,
  output logic [REG_DATA_WIDTH-1:0] mem_addr_o,
  output logic [REG_DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [REG_DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                      mem_ready_i,
  // status
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned CNT_W = 8;
  // Abort fires on the SERVE cycle whose stall would bring the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SERVE_I = 2'd1;
  localparam logic [1:0] S_SERVE_D = 2'd2;

  logic [1:0]                state_q, state_d;
  logic                      last_data_q, last_data_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [REG_DATA_WIDTH-1:0] addr_q, addr_d;
  logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      we_q, we_d;
  logic                      i_done_q, i_done_d;
  logic                      d_done_q, d_done_d;
  logic                      err_q, err_d;
  logic [REG_DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [REG_DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                      i_gnt_c, d_gnt_c;
  logic                      serve_d_c;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_data_q <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      err_q       <= err_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Arbitration, grant latching, completion and timeout.
  always_comb begin
    state_d     = state_q;
    last_data_d = last_data_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_gnt_c     = 1'b0;
    d_gnt_c     = 1'b0;
    serve_d_c   = (state_q == S_SERVE_D);

    case (state_q)
      S_IDLE: begin
        // Data wins unless it was the one served last and fetch is also asking.
        if (d_req_i && (!i_req_i || !last_data_q)) begin
          d_gnt_c = 1'b1;
          state_d = S_SERVE_D;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          we_d    = d_we_i;
          cnt_d   = '0;
        end else if (i_req_i) begin
          i_gnt_c = 1'b1;
          state_d = S_SERVE_I;
          addr_d  = REG_DATA_WIDTH'(i_addr_i);
          wdata_d = '0;
          we_d    = 1'b0;
          cnt_d   = '0;
        end
      end

      S_SERVE_I, S_SERVE_D: begin
        if (mem_ready_i) begin
          state_d     = S_IDLE;
          last_data_d = serve_d_c;
          if (serve_d_c) begin
            d_done_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = mem_rdata_i;
            end
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata_i;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Timeout: complete with error and a zero read word.
          state_d     = S_IDLE;
          last_data_d = serve_d_c;
          err_d       = 1'b1;
          if (serve_d_c) begin
            d_done_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = '0;
            end
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Grants are combinational; reset masks them so they drop immediately.
  assign i_gnt_o     = i_gnt_c & rst_n;
  assign d_gnt_o     = d_gnt_c & rst_n;

  assign i_done_o    = i_done_q;
  assign d_done_o    = d_done_q;
  assign err_o       = err_q;
  assign i_rdata_o   = i_rdata_q;
  assign d_rdata_o   = d_rdata_q;

  assign busy_o      = (state_q != S_IDLE);
  assign mem_ce_o    = busy_o;
  assign mem_we_o    = busy_o & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule
